window_sum3x3: RTL and testbench
================================

Name: window_sum3x3

Overview:
- Upstream neighbour of the averaging stage: takes a raster pixel stream and emits the 3x3 neighbourhood sum for every interior pixel position.
- Output width is PIXEL_WIDTH+4 and feeds the averaging stage's data/valid inputs directly.
- Holds two line buffers, column/row position counters and a 2-stage adder pipeline.

Parameters:
- PIXEL_WIDTH, 8, bits per input pixel.
- IMG_WIDTH, 640, pixels per line; legal range 3..4096.
- IMG_HEIGHT, 480, lines per frame; legal range 3..4096.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- arstn  input  1  asynchronous active-low reset.
- din_valid  input  1  pixel qualifier; one pixel accepted per cycle when high.
- din_sof  input  1  start-of-frame; sampled only when din_valid=1.
- din_data  input  PIXEL_WIDTH  pixel value, unsigned.
- dout_valid  output  1  window-sum qualifier.
- dout_data  output  PIXEL_WIDTH+4  unsigned sum of 9 pixels.

Behaviour:
- Reset values: dout_valid=0, dout_data=0, column counter=0, row counter=0, all pipeline valid flags=0, column-sum shift registers=0.
- Line buffer contents are not reset. Stale contents never reach the output because of row gating.
- Position tracking:
  - Accepted pixel takes position (row,col) from the counters.
  - col increments per accepted pixel and wraps IMG_WIDTH-1 -> 0; row increments on that wrap.
  - row wraps IMG_HEIGHT-1 -> 0, which starts a new frame.
  - Cycles with din_valid=0 change no counter, buffer or shift register.
- Resync: din_valid=1 with din_sof=1 forces the pixel's position to (0,0), and counters continue from (0,1). This applies mid-frame too, discarding the partial frame. din_sof with din_valid=0 is ignored.
- Line buffers (depth IMG_WIDTH each), on accepted pixel at col c:
  - Read lb1[c] (row-1) and lb2[c] (row-2).
  - Write lb2[c]<=lb1[c] and lb1[c]<=din_data, in the same cycle.
  - Read-before-write at the same address.
- Stage 1 (cycle T+1 for a pixel accepted at T):
  - colsum = din_data + lb1[c] + lb2[c], width PIXEL_WIDTH+2.
  - Register it with a valid flag and tags row>=2 and col>=2.
- Stage 2 (T+2):
  - Shift register of 3 column sums, which shifts only when stage-1 valid.
  - dout_data = cs0+cs1+cs2 (the new colsum plus the two previous ones), width PIXEL_WIDTH+4.
  - No saturation is needed: max 9*(2^PIXEL_WIDTH-1) fits.
- Output:
  - dout_valid=1 exactly at T+2 for each accepted pixel with row>=2 and col>=2.
  - The sum is over rows row-2..row and cols col-2..col. This is the window whose bottom-right corner is the accepted pixel.
  - Otherwise dout_valid=0, and dout_data holds its last value.
  - Fixed latency 2 cycles; no backpressure. Downstream always accepts.
- Per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) output beats.
- Line-start boundary: column sums from the previous line's last two columns are flushed by the col>=2 gating. The first two sums of a line never produce output.
- Reset mid-operation: all outputs drop to 0 asynchronously. After release, the next accepted pixel is (0,0) whether or not din_sof is set.

Decomposition:
- Package window_pkg: SUM_WIDTH = PIXEL_WIDTH+4 and COLSUM_WIDTH = PIXEL_WIDTH+2 as functions of PIXEL_WIDTH, plus a shared counter-width function (ceil log2).
- Sub-module line_buffer:
  - Single-port-read, single-port-write, depth IMG_WIDTH, width PIXEL_WIDTH.
  - Combinational read, registered write.
  - Instantiated twice, chained lb1 -> lb2.

Test Plan:
- IMG 4x4, all pixels 1, continuous valid, sof on first pixel -> 4 beats, each dout_data=9; first beat 2 cycles after pixel (2,2) accepted.
- IMG 5x3, all pixels 255 -> 3 beats, each 2295 (0x8F7), no overflow.
- IMG 4x4, pixel = 4*row+col (0..15) -> sums 45, 54, 81, 90, in that order.
- Same ramp with din_valid toggled 1/0 every cycle -> identical sums; each dout_valid exactly 2 cycles after its triggering accepted pixel.
- Two back-to-back 4x4 frames, second frame all 2 -> frame-2 beats all 18; no beat mixes frame-1 data.
- arstn pulsed after 6 pixels, then a full 4x4 all-1 frame without sof -> dout_valid low during reset, then exactly 4 beats of 9.
- din_sof asserted at pixel 7 of a 4x4 frame -> counters resync and the next 16 pixels yield exactly 4 beats.

Source files
------------

// File: rtl/window_pkg.sv
// Shared widths and helpers for the 3x3 window-sum datapath.
package window_pkg;

  // Width of a full 3x3 sum: 9 * (2^pw - 1) < 2^(pw+4).
  function automatic int sum_width(input int pw);
    return pw + 4;
  endfunction

  // Width of a 3-pixel column sum: 3 * (2^pw - 1) < 2^(pw+2).
  function automatic int colsum_width(input int pw);
    return pw + 2;
  endfunction

  // Bits needed to hold values 0..n-1 (ceil log2, never below 1).
  function automatic int counter_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One raster line of pixel storage: combinational read, registered write.
// Contents are deliberately not reset; the consumer gates stale rows away.
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = counter_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Asynchronous read, so the old value is visible in the same cycle it is overwritten.
  assign rd_data = mem[rd_addr];

  // Store one pixel per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/window_sum3x3.sv
// 3x3 neighbourhood sum over a raster pixel stream.
//
// Stream semantics: din_valid qualifies din_data/din_sof; every cycle with
// din_valid=1 consumes exactly one pixel and there is no ready signal.
// dout_valid qualifies dout_data for one cycle; downstream must always accept.
// A beat appears two clock edges after the pixel forming the bottom-right
// corner of a complete window (row>=2 and col>=2).
module window_sum3x3
  import window_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                                clk,
  input  logic                                arstn,
  input  logic                                din_valid,
  input  logic                                din_sof,
  input  logic [PIXEL_WIDTH-1:0]              din_data,
  output logic                                dout_valid,
  output logic [sum_width(PIXEL_WIDTH)-1:0]   dout_data
);

  localparam int SUM_W = sum_width(PIXEL_WIDTH);
  localparam int CS_W  = colsum_width(PIXEL_WIDTH);
  localparam int COL_W = counter_width(IMG_WIDTH);
  localparam int ROW_W = counter_width(IMG_HEIGHT);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] MIN_COL  = COL_W'(2);
  localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(2);

  // Position counters: where the next accepted pixel lands unless din_sof resyncs.
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;

  // Position of the pixel currently on the input, after applying din_sof.
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] next_col;
  logic [ROW_W-1:0] next_row;
  logic             at_last_col;

  // Line buffer outputs: same column, one and two lines above.
  logic [PIXEL_WIDTH-1:0] lb1_rd;
  logic [PIXEL_WIDTH-1:0] lb2_rd;

  // Stage 1: column sum with its valid flag and window-completeness tags.
  logic            s1_valid;
  logic [CS_W-1:0] s1_colsum;
  logic            s1_row_ok;
  logic            s1_col_ok;

  // Stage 2 history: the two column sums preceding the one in stage 1.
  logic [CS_W-1:0] cs_prev1;
  logic [CS_W-1:0] cs_prev2;

  logic            window_ok;
  logic [SUM_W-1:0] window_sum;

  // Resolve the input pixel's position and the counter values that follow it.
  always_comb begin
    pix_col     = din_sof ? '0 : col_cnt;
    pix_row     = din_sof ? '0 : row_cnt;
    at_last_col = (pix_col == LAST_COL);
    next_col    = at_last_col ? '0 : pix_col + 1'b1;
    next_row    = pix_row;
    if (at_last_col) begin
      next_row = (pix_row == LAST_ROW) ? '0 : pix_row + 1'b1;
    end
  end

  // Advance the raster position on every accepted pixel.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (din_valid) begin
      col_cnt <= next_col;
      row_cnt <= next_row;
    end
  end

  // lb1 holds the previous line, lb2 the line before it; a pixel pushes the
  // column down by one line (lb1 -> lb2, din -> lb1) while both are read.
  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH),
    .AW    (COL_W)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (din_valid),
    .rd_addr (pix_col),
    .wr_addr (pix_col),
    .wr_data (din_data),
    .rd_data (lb1_rd)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH),
    .AW    (COL_W)
  ) u_lb2 (
    .clk     (clk),
    .wr_en   (din_valid),
    .rd_addr (pix_col),
    .wr_addr (pix_col),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  // Stage 1: vertical sum of the three pixels in this column, tagged with
  // whether the window ending here lies fully inside the current frame.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s1_valid  <= 1'b0;
      s1_colsum <= '0;
      s1_row_ok <= 1'b0;
      s1_col_ok <= 1'b0;
    end else begin
      s1_valid <= din_valid;
      if (din_valid) begin
        s1_colsum <= CS_W'(din_data) + CS_W'(lb1_rd) + CS_W'(lb2_rd);
        s1_row_ok <= (pix_row >= MIN_ROW);
        s1_col_ok <= (pix_col >= MIN_COL);
      end
    end
  end

  // Horizontal sum of the newest column sum and the two before it. Stale
  // history from the previous line is harmless because col>=2 gates it out.
  always_comb begin
    window_ok  = s1_valid && s1_row_ok && s1_col_ok;
    window_sum = SUM_W'(s1_colsum) + SUM_W'(cs_prev1) + SUM_W'(cs_prev2);
  end

  // Stage 2: shift column-sum history and register the output beat.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cs_prev1   <= '0;
      cs_prev2   <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
    end else begin
      dout_valid <= window_ok;
      if (s1_valid) begin
        cs_prev1 <= s1_colsum;
        cs_prev2 <= cs_prev1;
      end
      if (window_ok) begin
        dout_data <= window_sum;
      end
    end
  end

endmodule

// File: tb/tb_window_sum3x3.sv
// Bench for window_sum3x3: two instances (4x4 and 5x3 frames) driven with
// directed and random pixel streams, checked against an image-array model.
module tb_window_sum3x3;

  localparam int PW = 8;
  localparam int SW = PW + 4;

  typedef struct {
    logic [SW-1:0] d;
    int            cyc;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUTs ----------------
  logic          a_valid = 1'b0, a_sof = 1'b0;
  logic [PW-1:0] a_data = '0;
  logic          a_out_valid;
  logic [SW-1:0] a_out_data;

  logic          b_valid = 1'b0, b_sof = 1'b0;
  logic [PW-1:0] b_data = '0;
  logic          b_out_valid;
  logic [SW-1:0] b_out_data;

  window_sum3x3 #(.PIXEL_WIDTH(PW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk        (clk),
    .arstn      (arstn),
    .din_valid  (a_valid),
    .din_sof    (a_sof),
    .din_data   (a_data),
    .dout_valid (a_out_valid),
    .dout_data  (a_out_data)
  );

  window_sum3x3 #(.PIXEL_WIDTH(PW), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
    .clk        (clk),
    .arstn      (arstn),
    .din_valid  (b_valid),
    .din_sof    (b_sof),
    .din_data   (b_data),
    .dout_valid (b_out_valid),
    .dout_data  (b_out_data)
  );

  // ---------------- reference model ----------------
  // Each DUT: current raster position and the pixels seen in the current frame.
  int            mr [2];
  int            mc [2];
  logic [PW-1:0] img [2][20];
  exp_t          exp_a [$];
  exp_t          exp_b [$];

  function automatic int img_w(input int which);
    return (which == 0) ? 4 : 5;
  endfunction

  function automatic int img_h(input int which);
    return (which == 0) ? 4 : 3;
  endfunction

  task automatic model_step(input int which, input bit s, input logic [PW-1:0] d);
    int w, h, r, c, sum;
    exp_t e;
    w = img_w(which);
    h = img_h(which);
    if (s) begin
      mr[which] = 0;
      mc[which] = 0;
    end
    r = mr[which];
    c = mc[which];
    img[which][r*w + c] = d;
    if (r >= 2 && c >= 2) begin
      sum = 0;
      for (int y = r - 2; y <= r; y++)
        for (int x = c - 2; x <= c; x++)
          sum += int'(img[which][y*w + x]);
      e.d   = SW'(sum);
      e.cyc = cyc + 2;
      if (which == 0) exp_a.push_back(e);
      else            exp_b.push_back(e);
    end
    c++;
    if (c == w) begin
      c = 0;
      r++;
      if (r == h) r = 0;
    end
    mr[which] = r;
    mc[which] = c;
  endtask

  // ---------------- driver tasks ----------------
  // One cycle of stimulus on one DUT; the other DUT idles.
  task automatic pix(input int which, input bit v, input bit s, input logic [PW-1:0] d);
    @(negedge clk);
    if (which == 0) begin
      a_valid = v; a_sof = s; a_data = d;
      b_valid = 1'b0; b_sof = 1'b0;
    end else begin
      b_valid = v; b_sof = s; b_data = d;
      a_valid = 1'b0; a_sof = 1'b0;
    end
    if (v) model_step(which, s, d);
  endtask

  // Idle cycles; din_sof toggles randomly to show it is ignored without valid.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      a_sof = 1'($urandom_range(0, 1));
      b_sof = 1'($urandom_range(0, 1));
      a_data = PW'($urandom_range(0, 255));
      b_data = PW'($urandom_range(0, 255));
    end
  endtask

  // kind: 0 constant val, 1 ramp 4*row+col, 2 random. gap: 0 none, 1 alternate, 2 random.
  task automatic send_pixels(input int which, input int n, input int kind,
                             input logic [PW-1:0] val, input bit sof, input int gap);
    logic [PW-1:0] d;
    int w;
    w = img_w(which);
    for (int i = 0; i < n; i++) begin
      if (kind == 0)      d = val;
      else if (kind == 1) d = PW'(4 * (i / w) + (i % w));
      else                d = PW'($urandom_range(0, 255));
      if (gap == 1 && i > 0) idle(1);
      if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      pix(which, 1'b1, sof && (i == 0), d);
    end
  endtask

  task automatic send_frame(input int which, input int kind, input logic [PW-1:0] val,
                            input bit sof, input int gap);
    send_pixels(which, img_w(which) * img_h(which), kind, val, sof, gap);
  endtask

  task automatic pulse_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    #2 arstn = 1'b0;
    @(negedge clk);
    exp_a.delete();
    exp_b.delete();
    mr[0] = 0; mc[0] = 0;
    mr[1] = 0; mc[1] = 0;
    repeat (2) @(negedge clk);
    #2 arstn = 1'b1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [SW-1:0] last_a = '0;
  logic [SW-1:0] last_b = '0;
  bit done = 1'b0;
  bit final_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!arstn) begin
      chk("a_reset_valid", a_out_valid, 0);
      chk("a_reset_data",  a_out_data,  0);
      chk("b_reset_valid", b_out_valid, 0);
      chk("b_reset_data",  b_out_data,  0);
      last_a = '0;
      last_b = '0;
    end else begin
      // instance A
      if (a_out_valid) begin
        if (exp_a.size() == 0) begin
          chk("a_unexpected_beat", a_out_valid, 0);
        end else begin
          e = exp_a.pop_front();
          chk("a_data", a_out_data, e.d);
          chk("a_latency_cycle", cyc, e.cyc);
        end
        last_a = a_out_data;
      end else begin
        chk("a_hold", a_out_data, last_a);
        if (exp_a.size() > 0 && exp_a[0].cyc <= cyc) begin
          chk("a_missing_beat", a_out_valid, 1);
          void'(exp_a.pop_front());
        end
      end
      // instance B
      if (b_out_valid) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected_beat", b_out_valid, 0);
        end else begin
          e = exp_b.pop_front();
          chk("b_data", b_out_data, e.d);
          chk("b_latency_cycle", cyc, e.cyc);
        end
        last_b = b_out_data;
      end else begin
        chk("b_hold", b_out_data, last_b);
        if (exp_b.size() > 0 && exp_b[0].cyc <= cyc) begin
          chk("b_missing_beat", b_out_valid, 1);
          void'(exp_b.pop_front());
        end
      end
    end
    if (done && !final_done) begin
      chk("a_beats_outstanding", exp_a.size(), 0);
      chk("b_beats_outstanding", exp_b.size(), 0);
      final_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    mr[0] = 0; mc[0] = 0;
    mr[1] = 0; mc[1] = 0;
    repeat (3) @(negedge clk);
    #2 arstn = 1'b1;
    idle(2);

    // 4x4 all ones: four beats of 9
    send_frame(0, 0, 8'd1, 1'b1, 0);
    idle(3);
    // 5x3 all 255: three beats of 2295
    send_frame(1, 0, 8'd255, 1'b1, 0);
    idle(3);
    // 4x4 ramp: 45, 54, 81, 90
    send_frame(0, 1, 8'd0, 1'b1, 0);
    idle(3);
    // same ramp with valid toggling every cycle
    send_frame(0, 1, 8'd0, 1'b1, 1);
    idle(3);
    // back-to-back frames, second all 2 and entered by position wrap
    send_frame(0, 2, 8'd0, 1'b1, 0);
    send_frame(0, 0, 8'd2, 1'b0, 0);
    idle(3);
    // reset after 6 pixels, then a full frame without sof
    send_pixels(0, 6, 2, 8'd0, 1'b1, 0);
    idle(3);
    pulse_reset();
    send_frame(0, 0, 8'd1, 1'b0, 0);
    idle(3);
    // sof on pixel 7 discards the partial frame
    send_pixels(0, 7, 2, 8'd0, 1'b1, 0);
    send_frame(0, 2, 8'd0, 1'b1, 0);
    idle(3);

    // random frames on both instances, random gaps and occasional resync
    for (int k = 0; k < 16; k++) begin
      int which;
      which = k % 2;
      if ($urandom_range(0, 3) == 0)
        send_pixels(which, $urandom_range(1, img_w(which) * img_h(which) - 1), 2, 8'd0,
                    1'($urandom_range(0, 1)), 2);
      send_frame(which, 2, 8'd0, 1'($urandom_range(0, 1)), 2);
    end
    idle(3);

    // asynchronous reset while beats are in flight, then recover
    send_frame(0, 2, 8'd0, 1'b1, 0);
    send_pixels(0, 11, 2, 8'd0, 1'b0, 0);
    pulse_reset();
    send_frame(0, 2, 8'd0, 1'b0, 2);
    send_frame(1, 2, 8'd0, 1'b0, 2);
    idle(5);

    done = 1'b1;
    repeat (3) @(negedge clk);
    if (!final_done) begin
      $display("FAIL final_check: monitor did not complete");
      $fatal(1, "monitor stalled");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
